// File: rtl/reg_file_pkg.sv
// reg_file_pkg
// Shared sizing constants for the architectural register file and its
// pending-write scoreboard, plus a small helper used for the scoreboard's
// "effective count" view.
// No ports (package).
package reg_file_pkg;

    localparam int XLEN      = 64;
    localparam int NREG      = 32;
    localparam int REG_IDX_W = 5;
    localparam int CNT_W     = 2;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Count as seen by decode this cycle: a retiring writer is already gone,
    // so it no longer blocks readers. Never goes below zero.
    function automatic logic [CNT_W-1:0] cnt_after_release(
        input logic [CNT_W-1:0] cnt,
        input logic             releasing
    );
        return (releasing && (cnt != '0)) ? cnt - CNT_ONE : cnt;
    endfunction

endpackage

// File: rtl/reg_file_if.sv
// reg_file_if
// Bundles the write-back write/release port, the decode request port and the
// register file's responses.
//   master : pipeline side (drives write-back and decode fields)
//   slave  : register file side (drives regfile_o_* fields)
interface reg_file_if;
    import reg_file_pkg::*;

    logic [REG_IDX_W-1:0] write_back_i_rd;
    logic [XLEN-1:0]      write_back_i_data;
    logic                 write_back_i_reg_wen;
    logic                 write_back_i_release;

    logic [REG_IDX_W-1:0] decode_i_rs1;
    logic [REG_IDX_W-1:0] decode_i_rs2;
    logic [REG_IDX_W-1:0] decode_i_rd;
    logic                 decode_i_rd_wen;
    logic                 decode_i_issue;

    logic [XLEN-1:0]      regfile_o_rs1_data;
    logic [XLEN-1:0]      regfile_o_rs2_data;
    logic                 regfile_o_rs1_busy;
    logic                 regfile_o_rs2_busy;
    logic                 regfile_o_issue_stall;
    logic                 regfile_o_err;

    modport master (
        output write_back_i_rd, write_back_i_data, write_back_i_reg_wen,
               write_back_i_release, decode_i_rs1, decode_i_rs2, decode_i_rd,
               decode_i_rd_wen, decode_i_issue,
        input  regfile_o_rs1_data, regfile_o_rs2_data, regfile_o_rs1_busy,
               regfile_o_rs2_busy, regfile_o_issue_stall, regfile_o_err
    );

    modport slave (
        input  write_back_i_rd, write_back_i_data, write_back_i_reg_wen,
               write_back_i_release, decode_i_rs1, decode_i_rs2, decode_i_rd,
               decode_i_rd_wen, decode_i_issue,
        output regfile_o_rs1_data, regfile_o_rs2_data, regfile_o_rs1_busy,
               regfile_o_rs2_busy, regfile_o_issue_stall, regfile_o_err
    );

endinterface

// File: rtl/reg_pending_ctr.sv
// reg_pending_ctr
// Pending-writer counter for one architectural register.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : an issued instruction will write this register
//   dec        : a marked instruction targeting this register retires
//   cnt        : current number of in-flight writers
//   underflow  : dec requested while cnt is already zero
module reg_pending_ctr
    import reg_file_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             underflow
);

    logic dec_ok;

    // A release with nothing outstanding is reported, not counted.
    assign dec_ok    = dec && (cnt != '0);
    assign underflow = dec && (cnt == '0);

    // inc and an effective dec cancel out; the max guard backs up the
    // decode stall so the count can never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && !dec_ok && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_ONE;
        end else if (dec_ok && !inc) begin
            cnt <= cnt - CNT_ONE;
        end
    end

endmodule

// File: rtl/reg_file.sv
// reg_file
// Integer register file with two bypassed combinational read ports and a
// per-register pending-write scoreboard driving decode's busy/stall signals.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : reg_file_if.slave; write-back write/release inputs, decode
//                rs1/rs2/rd/issue inputs, read data, busy, stall, sticky err
module reg_file
    import reg_file_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    reg_file_if.slave  bus
);

    logic [XLEN-1:0]  regs [NREG];
    logic [CNT_W-1:0] cnt [NREG];
    logic             underflow [NREG];

    logic [CNT_W-1:0] rs1_cnt_eff, rs2_cnt_eff, rd_cnt_eff;
    logic             rs1_busy, rs2_busy, issue_stall, issue_ok;
    logic             any_underflow, err;

    assign cnt[0]       = '0;
    assign underflow[0] = 1'b0;

    // x0 never takes a write, so it keeps its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.write_back_i_reg_wen && (bus.write_back_i_rd != '0)) begin
            regs[bus.write_back_i_rd] <= bus.write_back_i_data;
        end
    end

    // Write-first read ports: a same-cycle write-back overrides the array.
    always_comb begin
        bus.regfile_o_rs1_data = '0;
        bus.regfile_o_rs2_data = '0;
        if (bus.decode_i_rs1 != '0) begin
            bus.regfile_o_rs1_data =
                (bus.write_back_i_reg_wen && (bus.write_back_i_rd == bus.decode_i_rs1))
                ? bus.write_back_i_data : regs[bus.decode_i_rs1];
        end
        if (bus.decode_i_rs2 != '0) begin
            bus.regfile_o_rs2_data =
                (bus.write_back_i_reg_wen && (bus.write_back_i_rd == bus.decode_i_rs2))
                ? bus.write_back_i_data : regs[bus.decode_i_rs2];
        end
    end

    // Scoreboard view for decode, with this cycle's retirement already removed.
    always_comb begin
        rs1_cnt_eff = cnt_after_release(cnt[bus.decode_i_rs1],
            bus.write_back_i_release && (bus.write_back_i_rd == bus.decode_i_rs1));
        rs2_cnt_eff = cnt_after_release(cnt[bus.decode_i_rs2],
            bus.write_back_i_release && (bus.write_back_i_rd == bus.decode_i_rs2));
        rd_cnt_eff  = cnt_after_release(cnt[bus.decode_i_rd],
            bus.write_back_i_release && (bus.write_back_i_rd == bus.decode_i_rd));
    end

    assign rs1_busy    = (bus.decode_i_rs1 != '0) && (rs1_cnt_eff != '0);
    assign rs2_busy    = (bus.decode_i_rs2 != '0) && (rs2_cnt_eff != '0);
    // A destination already at the counter limit would overflow its counter.
    assign issue_stall = rs1_busy || rs2_busy ||
                         (bus.decode_i_rd_wen && (bus.decode_i_rd != '0) &&
                          (rd_cnt_eff == CNT_MAX));
    assign issue_ok    = bus.decode_i_issue && !issue_stall;

    for (genvar i = 1; i < NREG; i++) begin : g_ctr
        reg_pending_ctr u_ctr (
            .clk       (clk),
            .rst_n     (rst_n),
            .inc       (issue_ok && bus.decode_i_rd_wen &&
                        (bus.decode_i_rd == REG_IDX_W'(i))),
            .dec       (bus.write_back_i_release &&
                        (bus.write_back_i_rd == REG_IDX_W'(i))),
            .cnt       (cnt[i]),
            .underflow (underflow[i])
        );
    end

    always_comb begin
        any_underflow = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            any_underflow = any_underflow | underflow[i];
        end
    end

    // Sticky until reset: an unmatched release means the scoreboard is out of sync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (any_underflow) begin
            err <= 1'b1;
        end
    end

    assign bus.regfile_o_rs1_busy    = rs1_busy;
    assign bus.regfile_o_rs2_busy    = rs2_busy;
    assign bus.regfile_o_issue_stall = issue_stall;
    assign bus.regfile_o_err         = err;

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file
// Directed bench for reg_file: reset values, bypassed reads, x0 handling,
// scoreboard busy/stall, counter limit and sticky error with async reset.
// No ports.
module tb_reg_file;
    import reg_file_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    reg_file_if bus ();

    reg_file dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int check_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    localparam logic [XLEN-1:0] VAL_A = 64'hDEAD_BEEF_0000_0001;
    localparam logic [XLEN-1:0] VAL_B = 64'h0000_0000_1234_5678;
    localparam logic [XLEN-1:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    // Drives one full cycle's worth of pipeline inputs.
    task automatic apply_stimulus(
        input logic [REG_IDX_W-1:0] rs1,
        input logic [REG_IDX_W-1:0] rs2,
        input logic [REG_IDX_W-1:0] dec_rd,
        input logic                 rd_wen,
        input logic                 issue,
        input logic [REG_IDX_W-1:0] wb_rd,
        input logic [XLEN-1:0]      wb_data,
        input logic                 wen,
        input logic                 rel
    );
        bus.decode_i_rs1         = rs1;
        bus.decode_i_rs2         = rs2;
        bus.decode_i_rd          = dec_rd;
        bus.decode_i_rd_wen      = rd_wen;
        bus.decode_i_issue       = issue;
        bus.write_back_i_rd      = wb_rd;
        bus.write_back_i_data    = wb_data;
        bus.write_back_i_reg_wen = wen;
        bus.write_back_i_release = rel;
        #1;
    endtask

    task automatic check_output(
        input string           tag,
        input logic [XLEN-1:0] obs,
        input logic [XLEN-1:0] exp
    );
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        apply_stimulus(5'd5, 5'd31, 5'd0, 1'b0, 1'b0, 5'd0, '0, 1'b0, 1'b0);
        check_output("reset_rs1_data", bus.regfile_o_rs1_data, '0);
        check_output("reset_rs2_data", bus.regfile_o_rs2_data, '0);
        check_bit("reset_rs1_busy", bus.regfile_o_rs1_busy, 1'b0);
        check_bit("reset_rs2_busy", bus.regfile_o_rs2_busy, 1'b0);
        check_bit("reset_stall", bus.regfile_o_issue_stall, 1'b0);
        check_bit("reset_err", bus.regfile_o_err, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        // Same-cycle bypass, then array read
        apply_stimulus(5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, VAL_A, 1'b1, 1'b0);
        check_output("bypass_rs1", bus.regfile_o_rs1_data, VAL_A);
        tick();
        apply_stimulus(5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 5'd0, '0, 1'b0, 1'b0);
        check_output("array_rs1", bus.regfile_o_rs1_data, VAL_A);
        check_output("array_rs2", bus.regfile_o_rs2_data, VAL_A);

        // x0 write is discarded; issue to x0 does not count
        apply_stimulus(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, ONES, 1'b1, 1'b0);
        check_output("x0_bypass_rs1", bus.regfile_o_rs1_data, '0);
        check_bit("x0_issue_stall", bus.regfile_o_issue_stall, 1'b0);
        tick();
        apply_stimulus(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, '0, 1'b0, 1'b1);
        check_output("x0_rs1_data", bus.regfile_o_rs1_data, '0);
        check_bit("x0_rs1_busy", bus.regfile_o_rs1_busy, 1'b0);
        tick();
        check_bit("x0_release_no_err", bus.regfile_o_err, 1'b0);

        // Pending writer to x7
        apply_stimulus(5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 5'd0, '0, 1'b0, 1'b0);
        check_bit("x7_issue_stall", bus.regfile_o_issue_stall, 1'b0);
        tick();
        apply_stimulus(5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, '0, 1'b0, 1'b0);
        check_bit("x7_rs1_busy", bus.regfile_o_rs1_busy, 1'b1);
        check_bit("x7_stall", bus.regfile_o_issue_stall, 1'b1);
        tick();
        apply_stimulus(5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 5'd0, '0, 1'b0, 1'b0);
        check_bit("x7_rs2_busy", bus.regfile_o_rs2_busy, 1'b1);
        tick();
        apply_stimulus(5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, VAL_B, 1'b1, 1'b1);
        check_bit("x7_release_busy", bus.regfile_o_rs1_busy, 1'b0);
        check_bit("x7_release_stall", bus.regfile_o_issue_stall, 1'b0);
        check_output("x7_release_bypass", bus.regfile_o_rs1_data, VAL_B);
        tick();
        apply_stimulus(5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, '0, 1'b0, 1'b0);
        check_bit("x7_after_busy", bus.regfile_o_rs1_busy, 1'b0);
        check_output("x7_after_data", bus.regfile_o_rs1_data, VAL_B);

        // Fill x9's counter to its limit
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 5'd0, '0, 1'b0, 1'b0);
            check_bit("x9_fill_stall", bus.regfile_o_issue_stall, 1'b0);
            tick();
        end
        apply_stimulus(5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 5'd0, '0, 1'b0, 1'b0);
        check_bit("x9_full_stall", bus.regfile_o_issue_stall, 1'b1);
        tick();
        apply_stimulus(5'd0, 5'd0, 5'd9, 1'b0, 1'b1, 5'd0, '0, 1'b0, 1'b0);
        check_bit("x9_full_no_wen_stall", bus.regfile_o_issue_stall, 1'b0);
        apply_stimulus(5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 5'd9, '0, 1'b0, 1'b1);
        check_bit("x9_release_issue_stall", bus.regfile_o_issue_stall, 1'b0);
        tick();
        // Count must still be 3: drain it, watching busy via rs1=9
        apply_stimulus(5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, '0, 1'b0, 1'b1);
        check_bit("x9_drain1_busy", bus.regfile_o_rs1_busy, 1'b1);
        tick();
        apply_stimulus(5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, '0, 1'b0, 1'b1);
        check_bit("x9_drain2_busy", bus.regfile_o_rs1_busy, 1'b1);
        tick();
        apply_stimulus(5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, '0, 1'b0, 1'b1);
        check_bit("x9_drain3_busy", bus.regfile_o_rs1_busy, 1'b0);
        tick();
        check_bit("x9_drained_err", bus.regfile_o_err, 1'b0);

        // Underflow on x12 sets sticky err
        apply_stimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd12, '0, 1'b0, 1'b1);
        tick();
        check_bit("x12_err_set", bus.regfile_o_err, 1'b1);
        apply_stimulus(5'd0, 5'd0, 5'd20, 1'b1, 1'b1, 5'd0, '0, 1'b0, 1'b0);
        tick();
        apply_stimulus(5'd20, 5'd5, 5'd0, 1'b0, 1'b0, 5'd0, '0, 1'b0, 1'b0);
        tick();
        check_bit("err_sticky", bus.regfile_o_err, 1'b1);
        check_bit("x20_busy_pre_reset", bus.regfile_o_rs1_busy, 1'b1);
        check_output("x5_pre_reset", bus.regfile_o_rs2_data, VAL_A);

        // Asynchronous reset mid-run
        #1;
        rst_n = 1'b0;
        #1;
        check_bit("async_err_clear", bus.regfile_o_err, 1'b0);
        check_bit("async_x20_busy", bus.regfile_o_rs1_busy, 1'b0);
        check_output("async_x5_data", bus.regfile_o_rs2_data, '0);
        #1;
        rst_n = 1'b1;
        tick();
        check_bit("post_reset_busy", bus.regfile_o_rs1_busy, 1'b0);
        check_bit("post_reset_err", bus.regfile_o_err, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
